// File: rtl/stp_frame_buffer.sv
// Double-buffered serial-to-parallel frame collector for the FFT input path.
// Samples fill a back bank; completed frames are handed to a front bank that
// is held on data_par until the consumer accepts it with frame_ready.
module stp_frame_buffer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 48,
    parameter int unsigned BITREV_EN = 0,
    parameter int unsigned CNT_W     = 8,
    localparam int unsigned FILL_W   = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           it_cnt_strobe,
    input  logic [DATA_W-1:0]              serial_in,
    input  logic                           flush,
    input  logic                           frame_ready,
    output logic                           in_ready,
    output logic [DEPTH-1:0][DATA_W-1:0]   data_par,
    output logic                           frame_valid,
    output logic [FILL_W-1:0]              fill_cnt,
    output logic [CNT_W-1:0]               frame_cnt,
    output logic                           overrun
);

    // Elaboration-time parameter checks.
    if (DEPTH < 2) begin : g_depth_chk
        $error("stp_frame_buffer: DEPTH must be >= 2");
    end
    if ((BITREV_EN != 0) && ((DEPTH & (DEPTH - 1)) != 0)) begin : g_pow2_chk
        $error("stp_frame_buffer: BITREV_EN requires DEPTH to be a power of two");
    end

    // Encoding: bit0 = frame_valid, bit1 = back bank full.
    typedef enum logic [1:0] {
        S_EMPTY   = 2'b00,
        S_PRESENT = 2'b01,
        S_FULL    = 2'b11
    } state_t;

    state_t                         state_q, state_d;
    logic [DEPTH-1:0][DATA_W-1:0]   back_q;
    logic [IDX_W-1:0]               idx_c;
    logic                           wr_c;
    logic                           done_c;
    logic                           swap_c;

    assign in_ready    = (state_q != S_FULL);
    assign frame_valid = state_q[0];

    // Write index (natural or bit-reversed) and accepted-write/completion decode.
    always_comb begin
        idx_c = fill_cnt[IDX_W-1:0];
        if (BITREV_EN != 0) begin
            for (int b = 0; b < int'(IDX_W); b++) begin
                idx_c[b] = fill_cnt[IDX_W-1-b];
            end
        end
        wr_c   = it_cnt_strobe && in_ready && !flush;
        done_c = wr_c && (fill_cnt == FILL_W'(DEPTH - 1));
    end

    // Bank-state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Bank-state transitions and swap decision.
    always_comb begin
        state_d = state_q;
        swap_c  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (done_c) begin
                    state_d = S_PRESENT;
                    swap_c  = 1'b1;
                end
            end
            S_PRESENT: begin
                if (done_c) begin
                    if (frame_ready) begin
                        swap_c = 1'b1;
                    end else begin
                        state_d = S_FULL;
                    end
                end else if (frame_ready) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (flush) begin
                    state_d = frame_ready ? S_EMPTY : S_PRESENT;
                end else if (frame_ready) begin
                    state_d = S_PRESENT;
                    swap_c  = 1'b1;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // Back-bank fill, front-bank swap, frame counting and sticky overrun.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            back_q    <= '0;
            data_par  <= '0;
            fill_cnt  <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (flush) begin
                fill_cnt <= '0;
            end else if (wr_c) begin
                fill_cnt <= done_c ? '0 : fill_cnt + FILL_W'(1);
            end

            if (wr_c) begin
                back_q[idx_c] <= serial_in;
            end

            // The completing sample bypasses the back bank so the frame is
            // presented in the cycle right after its final strobe.
            if (swap_c) begin
                data_par <= back_q;
                if (done_c) begin
                    data_par[idx_c] <= serial_in;
                end
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            if (flush) begin
                overrun <= 1'b0;
            end else if (it_cnt_strobe && !in_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stp_frame_buffer.sv
// Randomized and directed bench for stp_frame_buffer: a natural-order DEPTH=48
// instance and a bit-reversed DEPTH=8 instance, checked every cycle against a
// frame-queue reference model.
module tb_stp_frame_buffer;

    localparam int unsigned W   = 16;
    localparam int unsigned D0  = 48;
    localparam int unsigned D1  = 8;
    localparam int unsigned CW  = 8;
    localparam int unsigned F0W = $clog2(D0 + 1);
    localparam int unsigned F1W = $clog2(D1 + 1);

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic                   stb0, fl0, fr0, ir0, fv0, ov0;
    logic [W-1:0]           d0;
    logic [D0-1:0][W-1:0]   dp0;
    logic [F0W-1:0]         fc0;
    logic [CW-1:0]          cnt0;

    logic                   stb1, fl1, fr1, ir1, fv1, ov1;
    logic [W-1:0]           d1;
    logic [D1-1:0][W-1:0]   dp1;
    logic [F1W-1:0]         fc1;
    logic [CW-1:0]          cnt1;

    stp_frame_buffer #(.DATA_W(W), .DEPTH(D0), .BITREV_EN(0), .CNT_W(CW)) u_nat (
        .clk(clk), .n_rst(n_rst), .it_cnt_strobe(stb0), .serial_in(d0),
        .flush(fl0), .frame_ready(fr0), .in_ready(ir0), .data_par(dp0),
        .frame_valid(fv0), .fill_cnt(fc0), .frame_cnt(cnt0), .overrun(ov0)
    );

    stp_frame_buffer #(.DATA_W(W), .DEPTH(D1), .BITREV_EN(1), .CNT_W(CW)) u_rev (
        .clk(clk), .n_rst(n_rst), .it_cnt_strobe(stb1), .serial_in(d1),
        .flush(fl1), .frame_ready(fr1), .in_ready(ir1), .data_par(dp1),
        .frame_valid(fv1), .fill_cnt(fc1), .frame_cnt(cnt1), .overrun(ov1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per unit, a presented frame, a pending back frame and a
    // partial frame being collected.
    int  dep [2] = '{48, 8};
    bit  brv [2] = '{1'b0, 1'b1};
    int  m_front [2][48];
    int  m_back  [2][48];
    int  m_fill  [2];
    int  m_cnt   [2];
    bit  m_valid [2];
    bit  m_bfull [2];
    bit  m_ovr   [2];

    task automatic chk(input string tag, input logic [767:0] got, input logic [767:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int place(input int u, input int k);
        int r = 0;
        int kk = k;
        if (!brv[u]) return k;
        for (int b = 1; b < dep[u]; b = b * 2) begin
            r  = r * 2 + (kk % 2);
            kk = kk / 2;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 48; i++) begin
                m_front[u][i] = 0;
                m_back[u][i]  = 0;
            end
            m_fill[u] = 0; m_cnt[u] = 0;
            m_valid[u] = 1'b0; m_bfull[u] = 1'b0; m_ovr[u] = 1'b0;
        end
    endtask

    task automatic take_back(input int u);
        for (int i = 0; i < dep[u]; i++) m_front[u][i] = m_back[u][i];
        m_cnt[u] = (m_cnt[u] + 1) % 256;
    endtask

    task automatic model_step(input int u, input bit stb, input int d, input bit fl, input bit fr);
        bit rdy = !(m_bfull[u] && m_valid[u]);
        if (fl) begin
            m_fill[u] = 0; m_ovr[u] = 1'b0; m_bfull[u] = 1'b0;
            if (fr) m_valid[u] = 1'b0;
        end else begin
            if (stb && !rdy) m_ovr[u] = 1'b1;
            if (fr && m_valid[u]) begin
                if (m_bfull[u]) begin
                    take_back(u);
                    m_bfull[u] = 1'b0;
                end else begin
                    m_valid[u] = 1'b0;
                end
            end
            if (stb && rdy) begin
                m_back[u][place(u, m_fill[u])] = d;
                m_fill[u]++;
                if (m_fill[u] == dep[u]) begin
                    m_fill[u] = 0;
                    if (!m_valid[u]) begin
                        take_back(u);
                        m_valid[u] = 1'b1;
                    end else begin
                        m_bfull[u] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [767:0] exp_dp(input int u);
        logic [767:0] v = '0;
        for (int i = 0; i < dep[u]; i++) v[i*16 +: 16] = 16'(m_front[u][i]);
        return v;
    endfunction

    task automatic check_all();
        chk("in_ready0",    768'(ir0),  768'(!(m_bfull[0] && m_valid[0])));
        chk("frame_valid0", 768'(fv0),  768'(m_valid[0]));
        chk("fill_cnt0",    768'(fc0),  768'(m_fill[0]));
        chk("frame_cnt0",   768'(cnt0), 768'(m_cnt[0]));
        chk("overrun0",     768'(ov0),  768'(m_ovr[0]));
        chk("data_par0",    768'(dp0),  exp_dp(0));
        chk("in_ready1",    768'(ir1),  768'(!(m_bfull[1] && m_valid[1])));
        chk("frame_valid1", 768'(fv1),  768'(m_valid[1]));
        chk("fill_cnt1",    768'(fc1),  768'(m_fill[1]));
        chk("frame_cnt1",   768'(cnt1), 768'(m_cnt[1]));
        chk("overrun1",     768'(ov1),  768'(m_ovr[1]));
        chk("data_par1",    768'(dp1),  exp_dp(1));
    endtask

    // One clock: check outputs at the falling edge, then drive unit u (the
    // other unit idles) and advance the model to the next rising edge.
    task automatic cyc(input int u, input bit stb, input int d, input bit fl, input bit fr);
        @(negedge clk);
        check_all();
        stb0 = 1'b0; d0 = '0; fl0 = 1'b0; fr0 = 1'b0;
        stb1 = 1'b0; d1 = '0; fl1 = 1'b0; fr1 = 1'b0;
        if (u == 0) begin
            stb0 = stb; d0 = W'(d); fl0 = fl; fr0 = fr;
        end else begin
            stb1 = stb; d1 = W'(d); fl1 = fl; fr1 = fr;
        end
        model_step(u, stb, d & 16'hFFFF, fl, fr);
        model_step(1 - u, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic rand_run(input int u, input int n);
        for (int k = 0; k < n; k++) begin
            cyc(u, $urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)),
                $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0);
        end
    endtask

    int br_exp [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    initial begin
        n_rst = 1'b0;
        stb0 = 1'b0; d0 = '0; fl0 = 1'b0; fr0 = 1'b0;
        stb1 = 1'b0; d1 = '0; fl1 = 1'b0; fr1 = 1'b0;
        model_reset();
        #3;
        check_all();
        chk("rst_in_ready", 768'(ir0), 768'(1));
        @(negedge clk);
        n_rst = 1'b1;

        // Natural order frame 0x0..0x2F.
        for (int i = 0; i < 48; i++) cyc(0, 1'b1, i, 1'b0, 1'b0);
        idle();
        chk("nat_valid", 768'(fv0), 768'(1));
        chk("nat_cnt",   768'(cnt0), 768'(1));
        chk("nat_fill",  768'(fc0), 768'(0));
        chk("nat_dp5",   768'(dp0[5]), 768'(5));

        // Consume, then a gapped fill and consume again.
        cyc(0, 1'b0, 0, 1'b0, 1'b1);
        idle();
        chk("ready_drop", 768'(fv0), 768'(0));
        for (int i = 0; i < 48; i++) begin
            repeat ($urandom_range(0, 3)) idle();
            cyc(0, 1'b1, 16'h40 + i, 1'b0, 1'b0);
        end
        cyc(0, 1'b0, 0, 1'b0, 1'b1);
        idle();
        chk("gap_drop", 768'(fv0), 768'(0));

        // Backpressure with two frames and one extra strobe.
        for (int i = 0; i < 48; i++) cyc(0, 1'b1, i, 1'b0, 1'b0);
        for (int i = 0; i < 48; i++) cyc(0, 1'b1, 16'h100 + i, 1'b0, 1'b0);
        cyc(0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        idle();
        chk("bp_in_ready", 768'(ir0), 768'(0));
        chk("bp_overrun",  768'(ov0), 768'(1));
        chk("bp_dp0",      768'(dp0[0]), 768'(0));
        cyc(0, 1'b0, 0, 1'b0, 1'b1);
        idle();
        chk("bp_swap_dp0",    768'(dp0[0]), 768'(16'h100));
        chk("bp_swap_ready",  768'(ir0), 768'(1));
        cyc(0, 1'b0, 0, 1'b0, 1'b1);
        cyc(0, 1'b0, 0, 1'b1, 1'b0);

        // Completion coincident with consumer accept.
        for (int i = 0; i < 48; i++) cyc(0, 1'b1, 16'h300 + i, 1'b0, 1'b0);
        for (int i = 0; i < 47; i++) cyc(0, 1'b1, 16'h400 + i, 1'b0, 1'b0);
        cyc(0, 1'b1, 16'h42F, 1'b0, 1'b1);
        idle();
        chk("sim_valid", 768'(fv0), 768'(1));
        chk("sim_cnt",   768'(cnt0), 768'(6));
        chk("sim_dp47",  768'(dp0[47]), 768'(16'h42F));
        cyc(0, 1'b0, 0, 1'b0, 1'b1);

        // Flush a partial frame, then fill a fresh one.
        for (int i = 0; i < 20; i++) cyc(0, 1'b1, 16'h500 + i, 1'b0, 1'b0);
        cyc(0, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 48; i++) cyc(0, 1'b1, 16'h200 + i, 1'b0, 1'b0);
        idle();
        chk("fl_dp0",  768'(dp0[0]),  768'(16'h200));
        chk("fl_dp47", 768'(dp0[47]), 768'(16'h22F));
        chk("fl_cnt",  768'(cnt0), 768'(7));

        rand_run(0, 1500);

        // Asynchronous reset in the middle of a frame.
        cyc(0, 1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) cyc(0, 1'b1, 16'h600 + i, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("pre_rst_fill", 768'(fc0), 768'(30));
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_fill", 768'(fc0), 768'(0));
        @(negedge clk);
        n_rst = 1'b1;

        // Bit-reversed placement, DEPTH=8.
        for (int i = 0; i < 8; i++) cyc(1, 1'b1, i, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 8; i++) chk($sformatf("brev_dp%0d", i), 768'(dp1[i]), 768'(br_exp[i]));
        chk("brev_cnt", 768'(cnt1), 768'(1));

        rand_run(1, 600);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
